// File: rtl/uart_frame_loop_pkg.sv
// Shared definitions for the UART frame loopback engine: mode codes,
// transmit FSM state encodings and counter widths.
package uart_frame_loop_pkg;

   typedef enum logic [1:0] {
      MODE_ECHO = 2'd0,
      MODE_REV  = 2'd1,
      MODE_INV  = 2'd2,
      MODE_SINK = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START     = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4
   } state_e;

   localparam int CNT_W  = 12;
   localparam int DISP_W = 2 * CNT_W;

endpackage

// File: rtl/uart_frame_loop_fifo.sv
// Synchronous frame FIFO with a combinational head output; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module frame_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full    = (cnt_q == LW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem_q[rd_ptr_q];
   assign level   = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + LW'(1);
         2'b01:   cnt_d = cnt_q - LW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; only the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_frame_loop.sv
// Frame loopback: buffers received frames, transforms each by mode and
// hands it to the packet transmitter over a start/busy handshake.
module uart_frame_loop
   import uart_frame_loop_pkg::*;
#(
   parameter int PKT_BYTES = 16,
   parameter int DEPTH     = 4,
   parameter int BUSY_WAIT = 15
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic                        recv_done,
   input  logic [8*PKT_BYTES-1:0]      recv_data,
   input  logic                        tx_busy,
   input  logic [1:0]                  mode,
   output logic                        send_en,
   output logic [8*PKT_BYTES-1:0]      send_data,
   output logic [23:0]                 disp_data,
   output logic                        disp_en,
   output logic                        overflow,
   output logic [$clog2(DEPTH):0]      fifo_level
);

   localparam int W      = 8 * PKT_BYTES;
   localparam int WAIT_W = $clog2(BUSY_WAIT + 1);

   state_e              state_q, state_d;
   logic [W-1:0]        send_data_q, send_data_d;
   logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [DISP_W-1:0]   disp_data_q;
   logic                disp_en_q;
   logic                overflow_q, overflow_d;

   logic [W-1:0]        fifo_dout;
   logic                fifo_full, fifo_empty, fifo_pop, push_accepted;

   function automatic logic [W-1:0] xform(input logic [W-1:0] f, input mode_e m);
      logic [W-1:0] r;
      r = f;
      case (m)
         MODE_REV: for (int i = 0; i < PKT_BYTES; i++) r[8*i +: 8] = f[8*(PKT_BYTES-1-i) +: 8];
         MODE_INV: r = ~f;
         default:  r = f;
      endcase
      return r;
   endfunction

   assign fifo_pop      = (state_q == LOAD);
   assign push_accepted = !fifo_full || (fifo_pop && !fifo_empty);

   frame_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .push  (recv_done),
      .pop   (fifo_pop),
      .din   (recv_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      state_d     = state_q;
      send_data_d = send_data_q;
      tx_cnt_d    = tx_cnt_q;
      wait_d      = wait_q;
      send_en     = 1'b0;
      case (state_q)
         IDLE:      if (!fifo_empty && !tx_busy) state_d = LOAD;
         LOAD: begin
            // Sink mode drains the head frame without touching send_data.
            if (mode_e'(mode) == MODE_SINK) begin
               state_d = IDLE;
            end else begin
               send_data_d = xform(fifo_dout, mode_e'(mode));
               state_d     = START;
            end
         end
         START: begin
            send_en  = 1'b1;
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
            wait_d   = '0;
            state_d  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy)                                state_d = WAIT_DONE;
            else if (wait_q == WAIT_W'(BUSY_WAIT - 1))  state_d = IDLE;
            else                                        wait_d  = wait_q + WAIT_W'(1);
         end
         WAIT_DONE: if (!tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   assign rx_cnt_d   = recv_done ? rx_cnt_q + CNT_W'(1) : rx_cnt_q;
   assign overflow_d = overflow_q | (recv_done & ~push_accepted);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         send_data_q <= '0;
         rx_cnt_q    <= '0;
         tx_cnt_q    <= '0;
         wait_q      <= '0;
         disp_data_q <= '0;
         disp_en_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         send_data_q <= send_data_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_cnt_q    <= tx_cnt_d;
         wait_q      <= wait_d;
         disp_data_q <= {rx_cnt_q, tx_cnt_q};
         disp_en_q   <= 1'b1;
         overflow_q  <= overflow_d;
      end
   end

   assign send_data = send_data_q;
   assign disp_data = disp_data_q;
   assign disp_en   = disp_en_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_frame_loop.sv
// Directed bench for uart_frame_loop: table of per-mode frames plus
// overflow, busy-timeout, sink and mid-transfer reset sequences.
module tb_uart_frame_loop;

   logic         sys_clk;
   logic         sys_rst_n;
   logic         recv_done;
   logic [127:0] recv_data;
   logic         tx_busy;
   logic [1:0]   mode;
   logic         send_en;
   logic [127:0] send_data;
   logic [23:0]  disp_data;
   logic         disp_en;
   logic         overflow;
   logic [2:0]   fifo_level;

   int total = 0;
   int bad   = 0;
   int n_sends = 0;

   typedef struct {
      logic [1:0]   mode;
      logic [127:0] frame;
      logic [127:0] exp_data;
      logic [23:0]  exp_disp;
   } vec_t;

   vec_t vecs[6];

   uart_frame_loop #(
      .PKT_BYTES (16),
      .DEPTH     (4),
      .BUSY_WAIT (15)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .recv_done  (recv_done),
      .recv_data  (recv_data),
      .tx_busy    (tx_busy),
      .mode       (mode),
      .send_en    (send_en),
      .send_data  (send_data),
      .disp_data  (disp_data),
      .disp_en    (disp_en),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   initial sys_clk = 1'b0;
   always #10 sys_clk = ~sys_clk;

   always @(posedge sys_clk) if (send_en) n_sends++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse(input logic [127:0] f);
      recv_data = f;
      recv_done = 1'b1;
      @(posedge sys_clk); #1;
      recv_done = 1'b0;
   endtask

   task automatic wait_send(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b1;
      while (!send_en) begin
         if (lat >= 40) begin
            ok = 1'b0;
            break;
         end
         @(posedge sys_clk); #1;
         lat++;
      end
   endtask

   // Transmitter model: busy rises right after the start pulse, then drops.
   task automatic handshake();
      tx_busy = 1'b1;
      repeat (4) begin @(posedge sys_clk); #1; end
      tx_busy = 1'b0;
      repeat (2) begin @(posedge sys_clk); #1; end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " send_en"},    128'(send_en),    128'(0));
      check({tag, " send_data"},  send_data,        128'(0));
      check({tag, " disp_data"},  128'(disp_data),  128'(0));
      check({tag, " disp_en"},    128'(disp_en),    128'(0));
      check({tag, " overflow"},   128'(overflow),   128'(0));
      check({tag, " fifo_level"}, 128'(fifo_level), 128'(0));
   endtask

   initial begin
      int          lat;
      int          gap;
      int          s0;
      bit          ok;
      logic [7:0]  b;

      vecs[0] = '{2'd0, 128'h000102030405060708090A0B0C0D0E0F,
                  128'h000102030405060708090A0B0C0D0E0F, 24'h001001};
      vecs[1] = '{2'd1, 128'h000102030405060708090A0B0C0D0E0F,
                  128'h0F0E0D0C0B0A09080706050403020100, 24'h002002};
      vecs[2] = '{2'd2, 128'h000102030405060708090A0B0C0D0E0F,
                  128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 24'h003003};
      vecs[3] = '{2'd0, 128'h112233445566778899AABBCCDDEEFF00,
                  128'h112233445566778899AABBCCDDEEFF00, 24'h004004};
      vecs[4] = '{2'd1, 128'h112233445566778899AABBCCDDEEFF00,
                  128'h00FFEEDDCCBBAA998877665544332211, 24'h005005};
      vecs[5] = '{2'd2, 128'h112233445566778899AABBCCDDEEFF00,
                  128'hEEDDCCBBAA99887766554433221100FF, 24'h006006};

      sys_rst_n = 1'b0;
      recv_done = 1'b0;
      recv_data = '0;
      tx_busy   = 1'b0;
      mode      = 2'd0;
      repeat (3) begin @(posedge sys_clk); #1; end
      check_all_zero("reset");

      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      check("disp_en after release", 128'(disp_en), 128'(1));

      for (int i = 0; i < 6; i++) begin
         mode = vecs[i].mode;
         pulse(vecs[i].frame);
         check($sformatf("v%0d level after push", i), 128'(fifo_level), 128'(1));
         wait_send(lat, ok);
         check($sformatf("v%0d send_en seen", i), 128'(ok), 128'(1));
         check($sformatf("v%0d latency", i), 128'(lat + 1), 128'(3));
         check($sformatf("v%0d send_data", i), send_data, vecs[i].exp_data);
         mode = ~vecs[i].mode;
         handshake();
         check($sformatf("v%0d send_data held", i), send_data, vecs[i].exp_data);
         check($sformatf("v%0d disp_data", i), 128'(disp_data), 128'(vecs[i].exp_disp));
         check($sformatf("v%0d level drained", i), 128'(fifo_level), 128'(0));
      end

      // Overflow: five frames while the transmitter is busy, depth four.
      mode    = 2'd0;
      tx_busy = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         b = 8'(k);
         pulse({16{b}});
      end
      check("ovf level", 128'(fifo_level), 128'(4));
      check("ovf flag", 128'(overflow), 128'(1));
      @(posedge sys_clk); #1;
      check("ovf disp rx", 128'(disp_data), 128'(24'h00B006));
      s0 = n_sends;
      tx_busy = 1'b0;
      for (int p = 0; p < 4; p++) begin
         wait_send(lat, ok);
         check($sformatf("ovf send %0d seen", p), 128'(ok), 128'(1));
         b = 8'(p + 1);
         check($sformatf("ovf send %0d order", p), send_data, {16{b}});
         handshake();
      end
      repeat (20) begin @(posedge sys_clk); #1; end
      check("ovf send count", 128'(n_sends - s0), 128'(4));
      check("ovf level drained", 128'(fifo_level), 128'(0));
      check("ovf flag sticky", 128'(overflow), 128'(1));
      check("ovf disp", 128'(disp_data), 128'(24'h00B00A));

      // Busy timeout: transmitter never responds.
      mode    = 2'd0;
      tx_busy = 1'b0;
      pulse(vecs[0].frame);
      pulse(vecs[3].frame);
      wait_send(lat, ok);
      check("tmo first seen", 128'(ok), 128'(1));
      check("tmo first data", send_data, vecs[0].exp_data);
      gap = 0;
      do begin
         @(posedge sys_clk); #1;
         gap++;
      end while (!send_en && gap < 40);
      check("tmo gap", 128'(gap), 128'(18));
      check("tmo second data", send_data, vecs[3].exp_data);
      repeat (25) begin @(posedge sys_clk); #1; end
      check("tmo disp", 128'(disp_data), 128'(24'h00D00C));
      check("tmo level", 128'(fifo_level), 128'(0));

      // Sink mode from a fresh reset.
      sys_rst_n = 1'b0;
      @(posedge sys_clk); #1;
      check("sink pre-reset overflow", 128'(overflow), 128'(0));
      check("sink pre-reset disp", 128'(disp_data), 128'(0));
      sys_rst_n = 1'b1;
      mode = 2'd3;
      s0 = n_sends;
      pulse(vecs[0].frame);
      pulse(vecs[3].frame);
      pulse(vecs[1].frame);
      repeat (10) begin @(posedge sys_clk); #1; end
      check("sink no send", 128'(n_sends - s0), 128'(0));
      check("sink level", 128'(fifo_level), 128'(0));
      check("sink disp", 128'(disp_data), 128'(24'h003000));
      check("sink send_data untouched", send_data, 128'(0));

      // Reset during WAIT_DONE with two frames queued.
      mode = 2'd0;
      pulse(vecs[1].frame);
      wait_send(lat, ok);
      check("rst send seen", 128'(ok), 128'(1));
      tx_busy = 1'b1;
      repeat (2) begin @(posedge sys_clk); #1; end
      pulse(vecs[3].frame);
      pulse(vecs[4].frame);
      check("rst queued level", 128'(fifo_level), 128'(2));
      sys_rst_n = 1'b0;
      @(posedge sys_clk); #1;
      check_all_zero("midrst");
      sys_rst_n = 1'b1;
      tx_busy   = 1'b0;
      s0 = n_sends;
      repeat (30) begin @(posedge sys_clk); #1; end
      check("midrst no send", 128'(n_sends - s0), 128'(0));
      check("midrst level", 128'(fifo_level), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
